// File: rtl/raster_scheduler.sv
// raster_scheduler: triangle FIFO + issue FSM in front of the rasterizer, with frame-buffer swapping.
// Optional macro CULL_DEGENERATE_EN drops zero-area triangles before they reach the rasterizer.
`default_nettype none

module raster_scheduler #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [25:0] FB0_BASE   = 26'h000_0000,
  parameter logic [25:0] FB1_BASE   = 26'h004_B000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [31:0] tri_x1,
  input  logic [31:0] tri_y1,
  input  logic [31:0] tri_x2,
  input  logic [31:0] tri_y2,
  input  logic [31:0] tri_x3,
  input  logic [31:0] tri_y3,
  input  logic [23:0] tri_c1,
  input  logic [23:0] tri_c2,
  input  logic [23:0] tri_c3,
  input  logic        tri_last,
  output logic [31:0] rast_x1,
  output logic [31:0] rast_y1,
  output logic [31:0] rast_x2,
  output logic [31:0] rast_y2,
  output logic [31:0] rast_x3,
  output logic [31:0] rast_y3,
  output logic [23:0] rast_color1,
  output logic [23:0] rast_color2,
  output logic [23:0] rast_color3,
  output logic [25:0] rast_addr,
  output logic        rast_valid,
  output logic        rast_last,
  input  logic        rast_fetch,
  input  logic        rast_done,
  output logic [25:0] display_base,
  output logic        frame_done,
  output logic [15:0] tri_issued,
  output logic [15:0] cull_count
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          EW       = 6 * 32 + 3 * 24 + 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] SWAP  = 2'd3;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [EW-1:0] head;
  logic [1:0]    state;
  logic          back_sel;
  logic          push;
  logic          pop;
  logic          empty;
  logic          degenerate;
  logic          cull;
  logic          issue;

  assign empty = (count == '0);
  assign push  = tri_valid && tri_ready;
  assign head  = mem[rd_ptr];
  assign pop   = (state == IDLE) && !empty;
  assign cull  = pop && degenerate;
  assign issue = pop && !degenerate;

  // Entry layout, LSB first: x1 y1 x2 y2 x3 y3 c1 c2 c3 last
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {tri_last, tri_c3, tri_c2, tri_c1,
                      tri_y3, tri_x3, tri_y2, tri_x2, tri_y1, tri_x1};
    end
  end

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // tri_ready is computed from the next occupancy so it never depends combinationally on pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tri_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      tri_ready <= (count_next != FULL_CNT);
    end
  end

`ifdef CULL_DEGENERATE_EN
  logic signed [63:0] dx21;
  logic signed [63:0] dy31;
  logic signed [63:0] dx31;
  logic signed [63:0] dy21;
  logic signed [63:0] area;

  assign dx21 = $signed({{32{head[95]}},  head[95:64]})   - $signed({{32{head[31]}}, head[31:0]});
  assign dy31 = $signed({{32{head[191]}}, head[191:160]}) - $signed({{32{head[63]}}, head[63:32]});
  assign dx31 = $signed({{32{head[159]}}, head[159:128]}) - $signed({{32{head[31]}}, head[31:0]});
  assign dy21 = $signed({{32{head[127]}}, head[127:96]})  - $signed({{32{head[63]}}, head[63:32]});
  assign area = (dx21 * dy31) - (dx31 * dy21);
  assign degenerate = (area == 64'sd0);
`else
  assign degenerate = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      back_sel    <= 1'b0;
      rast_x1     <= '0;
      rast_y1     <= '0;
      rast_x2     <= '0;
      rast_y2     <= '0;
      rast_x3     <= '0;
      rast_y3     <= '0;
      rast_color1 <= '0;
      rast_color2 <= '0;
      rast_color3 <= '0;
      rast_valid  <= 1'b0;
      rast_last   <= 1'b0;
      frame_done  <= 1'b0;
      tri_issued  <= '0;
      cull_count  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            rast_x1     <= head[31:0];
            rast_y1     <= head[63:32];
            rast_x2     <= head[95:64];
            rast_y2     <= head[127:96];
            rast_x3     <= head[159:128];
            rast_y3     <= head[191:160];
            rast_color1 <= head[215:192];
            rast_color2 <= head[239:216];
            rast_color3 <= head[263:240];
            rast_last   <= head[264];
            rast_valid  <= 1'b1;
            tri_issued  <= tri_issued + 16'd1;
            state       <= RUN;
          end else if (cull) begin
            cull_count <= cull_count + 16'd1;
            // A culled frame-ending triangle still closes the frame
            if (head[264]) begin
              frame_done <= 1'b1;
              state      <= SWAP;
            end
          end
        end
        RUN: begin
          if (rast_fetch) begin
            rast_valid <= 1'b0;
            state      <= rast_last ? FLUSH : IDLE;
          end
        end
        FLUSH: begin
          if (rast_done) begin
            frame_done <= 1'b1;
            state      <= SWAP;
          end
        end
        SWAP: begin
          back_sel <= ~back_sel;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rast_addr    = back_sel ? FB1_BASE : FB0_BASE;
  assign display_base = back_sel ? FB0_BASE : FB1_BASE;

endmodule

`default_nettype wire
